pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VEC, default 32'h00400000: value presented on pc_next while reset is asserted.
REQ-002 Parameter EXC_VEC, default 32'h00400004: exception handler entry address.
REQ-003 Parameter STALL_MAX, default 255: stall cycle count that raises stall_timeout.
REQ-004 PC_clk  in  1  clock; all state updates on the falling edge.
REQ-005 PC_rst  in  1  reset PC_rst, asynchronous, active-high.
REQ-006 pc_cur  in  32  current PC register value.
REQ-007 stall_req  in  1  multicycle unit busy; hold the PC.
REQ-008 br_taken / br_target  in  1/32  conditional branch redirect.
REQ-009 jmp / jmp_target  in  1/32  unconditional jump redirect.
REQ-010 eret / epc  in  1/32  exception return redirect.
REQ-011 exc_req / exc_code  in  1/5  exception request and cause.
REQ-012 pc_wena  out  1  write enable to the PC register.
REQ-013 pc_next  out  32  next PC value.
REQ-014 flush  out  1  squash the instruction fetched at pc_cur.
REQ-015 exc_cause  out  5  latched cause of the last taken exception.
REQ-016 stall_timeout  out  1  sticky flag: stall exceeded STALL_MAX.

Function
REQ-017 The FSM SHALL have three states: RUN, STALL and TRAP.
REQ-018 pc_wena, pc_next and flush SHALL be combinational decodes of the state, the buffers and the inputs; the state, pending buffer, stall counter, exc_cause and stall_timeout SHALL be registered.
REQ-019 In RUN with stall_req=0, pc_wena SHALL be 1 and pc_next SHALL be selected by priority: exc_req→EXC_VEC, then eret→epc, then jmp→jmp_target, then br_taken→br_target, else pc_cur+4 (modulo 2^32).
REQ-020 flush SHALL be 1 in any cycle where the selection is not pc_cur+4 and pc_wena=1.
REQ-021 A RUN cycle with exc_req=1 SHALL latch exc_code into exc_cause and go to TRAP, even when stall_req=1.
REQ-022 TRAP SHALL last exactly one cycle with pc_wena=0, then return to RUN.
REQ-023 Every input other than exc_req SHALL be ignored during TRAP.
REQ-024 In RUN with stall_req=1 and exc_req=0, pc_wena SHALL be 0.
REQ-025 In that case, any eret, jmp or br_taken redirect SHALL be stored in a one-entry pending buffer (valid bit and target), at the highest priority present.
REQ-026 In that case, the FSM SHALL go to STALL.
REQ-027 In STALL, pc_wena SHALL be 0 while stall_req=1.
REQ-028 In STALL, a new redirect SHALL overwrite the pending buffer only if the buffer is empty; the first redirect wins.
REQ-029 stall_cnt (8 bits) SHALL increment once per STALL cycle and saturate at 255.
REQ-030 stall_timeout SHALL set when stall_cnt reaches STALL_MAX and SHALL stay set until reset.
REQ-031 In STALL with stall_req=0, pc_wena SHALL be 1.
REQ-032 In that case, pc_next SHALL be the pending target if the buffer is valid, else pc_cur+4.
REQ-033 In that case, the buffer SHALL be cleared, stall_cnt SHALL be cleared, and the FSM SHALL go to RUN.
REQ-034 exc_req in STALL SHALL discard the pending buffer and take the exception as in REQ-021.
REQ-035 Simultaneous stall release and a new redirect input in STALL: the pending buffer SHALL win and the new input SHALL be ignored.

Reset
REQ-036 While PC_rst=1: state=RUN, pending buffer invalid with target 0, stall_cnt=0, exc_cause=0, stall_timeout=0.
REQ-037 While PC_rst=1: pc_wena=1, pc_next=RESET_VEC, flush=0.
REQ-038 Reset asserted mid-STALL or mid-TRAP SHALL abandon the operation with no pending redirect surviving.

Configuration
REQ-039 Macro PC_SEQ_EXC_EN defined: exception and eret logic per REQ-019 to REQ-034.
REQ-040 Macro PC_SEQ_EXC_EN undefined: exc_req, exc_code, eret and epc ignored; TRAP state absent; exc_cause tied to 0; all other behaviour unchanged.

Verification
REQ-041 Reset released, pc_cur=0x00400000, no requests -> pc_wena=1, pc_next=0x00400004, flush=0.
REQ-042 RUN, jmp=1 with jmp_target=0x00400100 and br_taken=1 with br_target=0x00400200 -> pc_next=0x00400100, flush=1.
REQ-043 stall_req=1 for 3 cycles with br_taken=1, br_target=0x00400040 in cycle 1 only -> pc_wena=0 for 3 cycles, then pc_next=0x00400040 on release.
REQ-044 STALL, exc_req=1 with exc_code=5'd12 and a redirect pending -> next cycle TRAP, exc_cause=12, pending cleared; pc_next=EXC_VEC on the cycle exc_req is sampled.
REQ-045 stall_req held for 256 cycles -> stall_timeout=1 after cycle 255, remains 1 after release; cleared only by PC_rst.
REQ-046 PC_rst asserted asynchronously mid-STALL with a pending redirect -> immediate pc_next=0x00400000; after release, a plain pc_cur+4 sequence with no pending redirect.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// PC sequencer bus: PC/redirect/exception requests in, PC write controls and status out.
interface pc_sequencer_if;
  logic [31:0] pc_cur;
  logic        stall_req;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        eret;
  logic [31:0] epc;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic        pc_wena;
  logic [31:0] pc_next;
  logic        flush;
  logic [4:0]  exc_cause;
  logic        stall_timeout;

  modport master (
    output pc_cur, stall_req, br_taken, br_target, jmp, jmp_target,
           eret, epc, exc_req, exc_code,
    input  pc_wena, pc_next, flush, exc_cause, stall_timeout
  );

  modport slave (
    input  pc_cur, stall_req, br_taken, br_target, jmp, jmp_target,
           eret, epc, exc_req, exc_code,
    output pc_wena, pc_next, flush, exc_cause, stall_timeout
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC selection with stall holding, one-entry pending redirect and exception trap.
// PC_SEQ_EXC_EN enables exception/eret handling and the TRAP state.
//
// state   | meaning
// S_RUN   | normal fetch; PC advances or redirects every cycle
// S_STALL | multicycle unit busy; PC held, first redirect kept pending
// S_TRAP  | one dead cycle after an exception is taken
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h00400000,
  parameter logic [31:0] EXC_VEC   = 32'h00400004,
  parameter int unsigned STALL_MAX = 255
) (
  input logic           PC_clk,
  input logic           PC_rst,
  pc_sequencer_if.slave bus
);

`ifdef PC_SEQ_EXC_EN
  typedef enum logic [1:0] {S_RUN = 2'd0, S_STALL = 2'd1, S_TRAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_RUN = 2'd0, S_STALL = 2'd1} state_t;
`endif

  state_t      state, state_nxt;
  logic        pend_vld, pend_vld_nxt;
  logic [31:0] pend_tgt, pend_tgt_nxt;
  logic [7:0]  stall_cnt, stall_cnt_nxt;
  logic [4:0]  cause, cause_nxt;
  logic        timeout, timeout_nxt;
  logic        wena, flush_c, stalling;
  logic [31:0] nxt, seq_pc;
  logic        exc_i, eret_i, redir_vld;
  logic [31:0] redir_tgt;

`ifdef PC_SEQ_EXC_EN
  assign exc_i  = bus.exc_req;
  assign eret_i = bus.eret;
`else
  assign exc_i  = 1'b0;
  assign eret_i = 1'b0;
  logic unused_exc;
  assign unused_exc = ^{EXC_VEC, bus.exc_req, bus.exc_code, bus.eret};
`endif

  assign seq_pc    = bus.pc_cur + 32'd4;
  assign redir_vld = eret_i | bus.jmp | bus.br_taken;
  assign redir_tgt = eret_i ? bus.epc : (bus.jmp ? bus.jmp_target : bus.br_target);

  always_comb begin
    state_nxt     = state;
    pend_vld_nxt  = pend_vld;
    pend_tgt_nxt  = pend_tgt;
    stall_cnt_nxt = 8'd0;
    cause_nxt     = cause;
    wena          = 1'b0;
    nxt           = seq_pc;
    flush_c       = 1'b0;
    stalling      = 1'b0;
`ifdef PC_SEQ_EXC_EN
    if (exc_i && state != S_TRAP) begin
      wena         = 1'b1;
      nxt          = EXC_VEC;
      flush_c      = 1'b1;
      cause_nxt    = bus.exc_code;
      pend_vld_nxt = 1'b0;
      state_nxt    = S_TRAP;
    end else
`endif
    case (state)
      S_RUN, S_STALL: begin
        if (bus.stall_req) begin
          // buffer is always empty on entry from RUN, so one rule covers both states
          stalling  = 1'b1;
          state_nxt = S_STALL;
          if (!pend_vld && redir_vld) begin
            pend_vld_nxt = 1'b1;
            pend_tgt_nxt = redir_tgt;
          end
        end else if (state == S_RUN) begin
          wena = 1'b1;
          if (redir_vld) begin
            nxt     = redir_tgt;
            flush_c = 1'b1;
          end
        end else begin
          wena         = 1'b1;
          pend_vld_nxt = 1'b0;
          state_nxt    = S_RUN;
          if (pend_vld) begin
            nxt     = pend_tgt;
            flush_c = 1'b1;
          end
        end
      end
      default: state_nxt = S_RUN;
    endcase
    // the RUN cycle that starts a stall counts as the first stalled cycle
    if (stalling)
      stall_cnt_nxt = (stall_cnt == 8'hFF) ? stall_cnt : stall_cnt + 8'd1;
  end

  assign timeout_nxt = timeout | (stalling && (32'(stall_cnt_nxt) == STALL_MAX));

  always_ff @(negedge PC_clk or posedge PC_rst) begin
    if (PC_rst) begin
      state     <= S_RUN;
      pend_vld  <= 1'b0;
      pend_tgt  <= 32'd0;
      stall_cnt <= 8'd0;
      cause     <= 5'd0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend_vld  <= pend_vld_nxt;
      pend_tgt  <= pend_tgt_nxt;
      stall_cnt <= stall_cnt_nxt;
      cause     <= cause_nxt;
      timeout   <= timeout_nxt;
    end
  end

  assign bus.pc_wena       = PC_rst | wena;
  assign bus.pc_next       = PC_rst ? RESET_VEC : nxt;
  assign bus.flush         = ~PC_rst & flush_c;
  assign bus.exc_cause     = cause;
  assign bus.stall_timeout = timeout;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vectors then random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_pc_sequencer;
  localparam logic [31:0] RESET_VEC = 32'h00400000;
  localparam logic [31:0] EXC_VEC   = 32'h00400004;
  localparam int          STALL_MAX = 255;
`ifdef PC_SEQ_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic PC_clk = 1'b0;
  logic PC_rst;
  pc_sequencer_if bus();

  pc_sequencer #(.RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC), .STALL_MAX(STALL_MAX)) dut (
    .PC_clk (PC_clk),
    .PC_rst (PC_rst),
    .bus    (bus.slave)
  );

  always #5 PC_clk = ~PC_clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic        s_rst, s_stall, s_br, s_jmp, s_eret, s_exc;
  logic [31:0] s_pc, s_bt, s_jt, s_ep;
  logic [4:0]  s_ec;

  // model: trap pending flag, "currently held" flag, pending-target queue, stall length
  bit          m_trap, m_stalled, m_tout;
  int          m_cnt;
  logic [4:0]  m_cause;
  logic [31:0] m_pend[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_trap = 0; m_stalled = 0; m_tout = 0; m_cnt = 0; m_cause = 5'd0;
    m_pend.delete();
  endtask

  task automatic idle();
    s_stall = 0; s_br = 0; s_jmp = 0; s_eret = 0; s_exc = 0;
    s_bt = 32'd0; s_jt = 32'd0; s_ep = 32'd0; s_ec = 5'd0;
  endtask

  task automatic drive();
    PC_rst         = s_rst;
    bus.pc_cur     = s_pc;
    bus.stall_req  = s_stall;
    bus.br_taken   = s_br;
    bus.br_target  = s_bt;
    bus.jmp        = s_jmp;
    bus.jmp_target = s_jt;
    bus.eret       = s_eret;
    bus.epc        = s_ep;
    bus.exc_req    = s_exc;
    bus.exc_code   = s_ec;
  endtask

  // inputs change mid-cycle (rising edge); DUT state moves on the falling edge
  task automatic step(input string tag);
    logic        e_wena, e_flush;
    logic [31:0] e_next, tgt;
    bit          eret_eff, exc_eff, redir;
    @(posedge PC_clk);
    drive();
    #1;
    if (s_rst) model_reset();
    chk({tag, ".cause"}, 32'(bus.exc_cause), 32'(m_cause));
    chk({tag, ".tout"}, 32'(bus.stall_timeout), 32'(m_tout));
    eret_eff = EXC_EN && s_eret;
    exc_eff  = EXC_EN && s_exc && !m_trap;
    redir    = eret_eff || s_jmp || s_br;
    tgt      = eret_eff ? s_ep : (s_jmp ? s_jt : s_bt);
    e_wena = 0; e_flush = 0; e_next = s_pc + 32'd4;
    if (s_rst) begin
      e_wena = 1; e_next = RESET_VEC;
    end else if (exc_eff) begin
      e_wena = 1; e_flush = 1; e_next = EXC_VEC;
      m_cause = s_ec; m_pend.delete(); m_trap = 1; m_stalled = 0; m_cnt = 0;
    end else if (m_trap) begin
      m_trap = 0;
    end else if (s_stall) begin
      if (redir && m_pend.size() == 0) m_pend.push_back(tgt);
      m_stalled = 1;
      if (m_cnt < 255) m_cnt++;
      if (m_cnt == STALL_MAX) m_tout = 1;
    end else begin
      e_wena = 1;
      if (m_pend.size() != 0) begin
        e_next = m_pend.pop_front(); e_flush = 1;
      end else if (!m_stalled && redir) begin
        e_next = tgt; e_flush = 1;
      end
      m_stalled = 0; m_cnt = 0;
    end
    chk({tag, ".wena"}, 32'(bus.pc_wena), 32'(e_wena));
    chk({tag, ".flush"}, 32'(bus.flush), 32'(e_flush));
    if (e_wena) chk({tag, ".next"}, bus.pc_next, e_next);
  endtask

  initial begin
    model_reset();
    idle();
    s_rst = 1; s_pc = RESET_VEC;
    drive();
    step("rst0");
    step("rst1");
    chk("rst_vec", bus.pc_next, 32'h00400000);

    s_rst = 0; s_pc = 32'h00400000;
    step("seq");
    chk("seq_next", bus.pc_next, 32'h00400004);

    s_pc = 32'h00400004; s_jmp = 1; s_jt = 32'h00400100; s_br = 1; s_bt = 32'h00400200;
    step("jmp_over_br");
    chk("jmp_over_br_next", bus.pc_next, 32'h00400100);

    idle(); s_pc = 32'h00400100; s_stall = 1; s_br = 1; s_bt = 32'h00400040;
    step("stl_br1");
    s_br = 0;
    step("stl_br2");
    step("stl_br3");
    s_stall = 0;
    step("stl_rel");
    chk("stl_rel_next", bus.pc_next, 32'h00400040);

    idle(); s_pc = 32'hFFFFFFFC;
    step("wrap");

    s_pc = 32'h00400010; s_stall = 1; s_jmp = 1; s_jt = 32'h00400A00;
    step("first1");
    s_jmp = 0; s_br = 1; s_bt = 32'h00400B00;
    step("first2");
    s_stall = 0; s_br = 0; s_jmp = 1; s_jt = 32'h00400C00;
    step("first_rel");
    chk("first_rel_next", bus.pc_next, 32'h00400A00);

    idle(); s_stall = 1;
    step("empty1");
    s_stall = 0; s_jmp = 1; s_jt = 32'h00400D00;
    step("empty_rel");

`ifdef PC_SEQ_EXC_EN
    idle(); s_eret = 1; s_ep = 32'h00401000; s_jmp = 1; s_jt = 32'h00402000;
    step("eret_pri");
    idle(); s_stall = 1; s_br = 1; s_bt = 32'h00400300;
    step("exc_stl1");
    s_br = 0; s_exc = 1; s_ec = 5'd12;
    step("exc_stl2");
    chk("exc_vec", bus.pc_next, EXC_VEC);
    idle(); s_stall = 1; s_jmp = 1; s_jt = 32'h00403000;
    step("trap");
    chk("trap_cause", 32'(bus.exc_cause), 32'd12);
    idle(); s_pc = 32'h00400004;
    step("post_trap");
    s_exc = 1; s_ec = 5'd3; s_stall = 1;
    step("exc_run_stall");
    idle();
    step("trap2");
    step("post_trap2");
`endif

    idle(); s_pc = 32'h00400020; s_stall = 1;
    for (int i = 1; i <= 256; i++) begin
      step("tout");
      if (i == 255) chk("tout_before", 32'(bus.stall_timeout), 32'd0);
      if (i == 256) chk("tout_after", 32'(bus.stall_timeout), 32'd1);
    end
    s_stall = 0;
    step("tout_rel");
    step("tout_sticky");
    chk("tout_sticky_val", 32'(bus.stall_timeout), 32'd1);

    s_stall = 1; s_jmp = 1; s_jt = 32'h00400E00;
    step("arst_stl1");
    s_jmp = 0;
    step("arst_stl2");
    @(posedge PC_clk);
    #2;
    s_rst = 1; PC_rst = 1'b1;
    #1;
    chk("arst_vec", bus.pc_next, 32'h00400000);
    chk("arst_wena", 32'(bus.pc_wena), 32'd1);
    idle();
    step("arst_hold");
    s_rst = 0; s_pc = 32'h00400000;
    step("arst_seq1");
    chk("arst_seq1_next", bus.pc_next, 32'h00400004);
    s_pc = 32'h00400004;
    step("arst_seq2");

    for (int i = 0; i < 800; i++) begin
      s_rst   = ($urandom_range(0, 99) == 0);
      s_stall = ($urandom_range(0, 9) < 4);
      s_br    = ($urandom_range(0, 3) == 0);
      s_jmp   = ($urandom_range(0, 4) == 0);
      s_eret  = ($urandom_range(0, 5) == 0);
      s_exc   = !m_trap && ($urandom_range(0, 14) == 0);
      s_pc    = $urandom() & 32'hFFFFFFFC;
      s_bt    = $urandom() & 32'hFFFFFFFC;
      s_jt    = $urandom() & 32'hFFFFFFFC;
      s_ep    = $urandom() & 32'hFFFFFFFC;
      s_ec    = 5'($urandom_range(0, 31));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
